// File: rtl/nts_rx_dispatcher_pkg.sv
// Shared types and constants for the NTS RX dispatcher.
package nts_rx_dispatcher_pkg;

    // Upper bound on the number of NTS engines a dispatcher can serve.
    localparam int unsigned NTS_ENGINES_MAX = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFwdEng,
        StFwdOther,
        StDiscard
    } state_t;

endpackage

// File: rtl/nts_rx_dispatcher_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping upward.
module nts_rx_dispatcher_rr_arbiter #(
    parameter int unsigned ENGINES = 4,
    parameter int unsigned PTR_W   = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
    input  logic [ENGINES-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [ENGINES-1:0] grant,
    output logic               valid
);

    // One extra bit so ptr + offset cannot overflow before the wrap
    logic [PTR_W:0] idx;

    // Scan ENGINES positions starting at ptr; first hit wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < ENGINES; i++) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(ENGINES)) begin
                idx = idx - (PTR_W + 1)'(ENGINES);
            end
            if (!valid && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nts_rx_dispatcher.sv
// Steers classified RX frames to an NTS engine, the CPU path, or the bit bucket.
module nts_rx_dispatcher
    import nts_rx_dispatcher_pkg::*;
#(
    parameter int unsigned ENGINES   = 4,
    parameter int unsigned MAX_WORDS = 200,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               i_clk,
    input  logic               i_areset,
    input  logic [63:0]        i_rx_data_be,
    input  logic [3:0]         i_rx_valid4bit,
    input  logic               i_packet_nts,
    input  logic               i_packet_other,
    input  logic               i_packet_drop,
    input  logic               i_ethernet_good,
    input  logic               i_ethernet_bad,
    input  logic               i_sof,
    input  logic [ENGINES-1:0] i_engine_ready,
    input  logic               i_other_ready,
    output logic [ENGINES-1:0] o_engine_we,
    output logic               o_other_we,
    output logic [63:0]        o_data,
    output logic [3:0]         o_valid4bit,
    output logic               o_commit,
    output logic               o_abort,
    output logic [CNT_W-1:0]   o_cnt_nts,
    output logic [CNT_W-1:0]   o_cnt_other,
    output logic [CNT_W-1:0]   o_cnt_drop,
    output logic [CNT_W-1:0]   o_cnt_busy,
    output logic [CNT_W-1:0]   o_cnt_bad
);

    localparam int unsigned PTR_W  = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

    state_t             state_q;
    logic [ENGINES-1:0] sel_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [WCNT_W-1:0]  wcnt_q;

    logic [ENGINES-1:0] grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [WCNT_W-1:0]  wcnt_inc;
    logic               eof;
    logic               in_fwd;
    logic               fwd_full;
    logic               sof_full;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    nts_rx_dispatcher_rr_arbiter #(
        .ENGINES(ENGINES),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req  (i_engine_ready),
        .ptr  (ptr_q),
        .grant(grant),
        .valid(grant_valid)
    );

    // Encode the one-hot grant and advance the pointer just past it
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < ENGINES; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
        ptr_next = (grant_idx == PTR_W'(ENGINES - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign eof      = i_ethernet_good | i_ethernet_bad;
    assign in_fwd   = (state_q == StFwdEng) || (state_q == StFwdOther);
    assign wcnt_inc = wcnt_q + 1'b1;
    assign fwd_full = (wcnt_inc == WCNT_W'(MAX_WORDS));
    // A one-word limit means the first word already hits the cap
    assign sof_full = (MAX_WORDS == 1);

    // Frame steering FSM; outputs and statistics are registered alongside state
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            ptr_q       <= '0;
            wcnt_q      <= '0;
            o_engine_we <= '0;
            o_other_we  <= 1'b0;
            o_data      <= '0;
            o_valid4bit <= '0;
            o_commit    <= 1'b0;
            o_abort     <= 1'b0;
            o_cnt_nts   <= '0;
            o_cnt_other <= '0;
            o_cnt_drop  <= '0;
            o_cnt_busy  <= '0;
            o_cnt_bad   <= '0;
        end else begin
            o_data      <= i_rx_data_be;
            o_valid4bit <= i_rx_valid4bit;
            o_engine_we <= '0;
            o_other_we  <= 1'b0;
            o_commit    <= 1'b0;
            o_abort     <= 1'b0;

            if (in_fwd && i_sof) begin
                // Missing EOF: close the old buffer; the new frame lost its first word
                o_engine_we <= (state_q == StFwdEng) ? sel_q : '0;
                o_other_we  <= (state_q == StFwdOther);
                o_abort     <= 1'b1;
                o_cnt_bad   <= sat_inc(o_cnt_bad);
                state_q     <= eof ? StIdle : StDiscard;
            end else if (i_sof) begin
                wcnt_q <= WCNT_W'(1);
                if (i_packet_drop) begin
                    o_cnt_drop <= sat_inc(o_cnt_drop);
                    state_q    <= eof ? StIdle : StDiscard;
                end else if (i_packet_nts) begin
                    if (grant_valid) begin
                        sel_q       <= grant;
                        ptr_q       <= ptr_next;
                        o_engine_we <= grant;
                        if (eof) begin
                            state_q <= StIdle;
                            if (i_ethernet_bad) begin
                                o_abort   <= 1'b1;
                                o_cnt_bad <= sat_inc(o_cnt_bad);
                            end else begin
                                o_commit  <= 1'b1;
                                o_cnt_nts <= sat_inc(o_cnt_nts);
                            end
                        end else if (sof_full) begin
                            o_abort   <= 1'b1;
                            o_cnt_bad <= sat_inc(o_cnt_bad);
                            state_q   <= StDiscard;
                        end else begin
                            state_q <= StFwdEng;
                        end
                    end else begin
                        o_cnt_busy <= sat_inc(o_cnt_busy);
                        state_q    <= eof ? StIdle : StDiscard;
                    end
                end else if (i_packet_other) begin
                    if (i_other_ready) begin
                        o_other_we <= 1'b1;
                        if (eof) begin
                            state_q <= StIdle;
                            if (i_ethernet_bad) begin
                                o_abort   <= 1'b1;
                                o_cnt_bad <= sat_inc(o_cnt_bad);
                            end else begin
                                o_commit    <= 1'b1;
                                o_cnt_other <= sat_inc(o_cnt_other);
                            end
                        end else if (sof_full) begin
                            o_abort   <= 1'b1;
                            o_cnt_bad <= sat_inc(o_cnt_bad);
                            state_q   <= StDiscard;
                        end else begin
                            state_q <= StFwdOther;
                        end
                    end else begin
                        o_cnt_busy <= sat_inc(o_cnt_busy);
                        state_q    <= eof ? StIdle : StDiscard;
                    end
                end else begin
                    state_q <= eof ? StIdle : StDiscard;
                end
            end else begin
                case (state_q)
                    StFwdEng, StFwdOther: begin
                        o_engine_we <= (state_q == StFwdEng) ? sel_q : '0;
                        o_other_we  <= (state_q == StFwdOther);
                        wcnt_q      <= wcnt_inc;
                        if (eof) begin
                            state_q <= StIdle;
                            if (i_ethernet_bad) begin
                                o_abort   <= 1'b1;
                                o_cnt_bad <= sat_inc(o_cnt_bad);
                            end else begin
                                o_commit <= 1'b1;
                                if (state_q == StFwdEng) begin
                                    o_cnt_nts <= sat_inc(o_cnt_nts);
                                end else begin
                                    o_cnt_other <= sat_inc(o_cnt_other);
                                end
                            end
                        end else if (fwd_full) begin
                            o_abort   <= 1'b1;
                            o_cnt_bad <= sat_inc(o_cnt_bad);
                            state_q   <= StDiscard;
                        end
                    end
                    StDiscard: begin
                        if (eof) begin
                            state_q <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
